// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU constants: md_op encodings emitted by the decoder and default latencies.
// MDU_MADD_EN enables the MADD/MADDU accumulate opcodes.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the multi-cycle unit; MADD/MADDU only exist when enabled.
    function automatic logic is_start_op(logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result.
// The acc port and the accumulate adder exist only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
`ifdef MDU_MADD_EN
    input  logic [63:0] acc,
`endif
    output logic [63:0] res,
    output logic        div_zero
);

    logic        signed_op;
    logic [63:0] a64, b64, prod;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag, divisor, q_mag, r_mag, quo, rem;

    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD);
        a64  = signed_op ? {{32{rs[31]}}, rs} : {32'h0, rs};
        b64  = signed_op ? {{32{rt[31]}}, rt} : {32'h0, rt};
        prod = a64 * b64;

        // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
        rs_neg  = signed_op & rs[31];
        rt_neg  = signed_op & rt[31];
        rs_mag  = rs_neg ? -rs : rs;
        rt_mag  = rt_neg ? -rt : rt;
        divisor = (rt == 32'h0) ? 32'h1 : rt_mag;
        q_mag   = rs_mag / divisor;
        r_mag   = rs_mag % divisor;
        quo     = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
        rem     = rs_neg ? -r_mag : r_mag;

        div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (rt == 32'h0);

        res = 64'h0;
        case (op)
            MD_MULT, MD_MULTU: res = prod;
            MD_DIV,  MD_DIVU:  res = {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: res = acc + prod;
`endif
            default:           res = 64'h0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide scheduler: owns HI/LO, models fixed latency, raises D-stage stall.
// Define MDU_MADD_EN to enable MADD/MADDU accumulation into {HI,LO}.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        int_req,
    input  logic        use_md_d,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] counter;
    logic [63:0]      pending, arith_res;
    logic             pend_dz, arith_dz;
    logic             start, is_div;

    mdu_arith u_arith (
        .op       (md_op),
        .rs       (rs_data),
        .rt       (rt_data),
`ifdef MDU_MADD_EN
        .acc      ({hi, lo}),
`endif
        .res      (arith_res),
        .div_zero (arith_dz)
    );

    always_comb begin
        start  = is_start_op(md_op) && !int_req && !busy;
        is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
    end

    // An in-flight op is never cancelled by int_req; only reset aborts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
            busy    <= 1'b0;
            pending <= '0;
            pend_dz <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (busy) begin
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
                busy <= 1'b0;
                if (!pend_dz) {hi, lo} <= pending;
            end
        end else if (start) begin
            pending <= arith_res;
            pend_dz <= arith_dz;
            counter <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy    <= 1'b1;
        end else if (!int_req) begin
            if (md_op == MD_MTHI) hi <= rs_data;
            if (md_op == MD_MTLO) lo <= rs_data;
        end
    end

    always_comb begin
        md_stall = use_md_d && (busy || start);
        md_out   = 32'h0;
        case (md_op)
            MD_MFHI: md_out = hi;
            MD_MFLO: md_out = lo;
            default: md_out = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, directed corner sequences, random vs reference model.
// Honours MDU_MADD_EN the same way as the design.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_data, rt_data;
    logic        int_req, use_md_d;
    logic        busy, md_stall;
    logic [31:0] md_out, hi, lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .int_req  (int_req),
        .use_md_d (use_md_d),
        .busy     (busy),
        .md_stall (md_stall),
        .md_out   (md_out),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: architectural HI/LO, cycles remaining, result waiting to land.
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic [63:0] m_pend;
    logic        m_dz;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
        int          cyc;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit ref_start_op(logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || op == 4'd9 || op == 4'd10;
`else
        return op >= 4'd1 && op <= 4'd4;
`endif
    endfunction

    // {div_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] ref_op(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                           logic [63:0] acc);
        logic [63:0] sp, up;
        int sa, sb;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'h0, a} * {32'h0, b};
        sa = a;
        sb = b;
        case (op)
            4'd1: return {1'b0, sp};
            4'd2: return {1'b0, up};
            4'd3: begin
                if (b == 32'h0) return {1'b1, 64'h0};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, a};
                return {1'b0, 32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (b == 32'h0) return {1'b1, 64'h0};
                return {1'b0, a % b, a / b};
            end
            4'd9:  return {1'b0, acc + sp};
            4'd10: return {1'b0, acc + up};
            default: return 65'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0; m_dz = 0;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ir, input logic ud);
        md_op = op; rs_data = a; rt_data = b; int_req = ir; use_md_d = ud;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check state after edge.
    task automatic tick();
        bit          st;
        logic [31:0] exp_out;
        logic [64:0] r;
        #2;
        st = ref_start_op(md_op) && !int_req && m_left == 0;
        exp_out = (md_op == 4'd5) ? m_hi : (md_op == 4'd6) ? m_lo : 32'h0;
        chk("md_stall", {63'h0, md_stall}, {63'h0, use_md_d && (m_left > 0 || st)});
        chk("md_out", {32'h0, md_out}, {32'h0, exp_out});
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_dz) {m_hi, m_lo} = m_pend;
        end else if (st) begin
            r = ref_op(md_op, rs_data, rt_data, {m_hi, m_lo});
            {m_dz, m_pend} = r;
            m_left = (md_op == 4'd3 || md_op == 4'd4) ? DC : MC;
        end else if (!int_req) begin
            if (md_op == 4'd7) m_hi = rs_data;
            if (md_op == 4'd8) m_lo = rs_data;
        end
        #1;
        chk("busy", {63'h0, busy}, {63'h0, m_left > 0});
        chk("hi", {32'h0, hi}, {32'h0, m_hi});
        chk("lo", {32'h0, lo}, {32'h0, m_lo});
    endtask

    // Issue an op for one cycle, then count cycles with busy high (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        set_in(op, a, b, 0, 0);
        tick();
        set_in(MD_NONE, 0, 0, 0, 0);
        n = 0;
        while (busy && n < 60) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        clk = 0;
        set_in(MD_MFHI, 0, 0, 0, 1);
        reset = 1;
        model_reset();
        #1;
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_hi", {32'h0, hi}, 64'h0);
        chk("reset_lo", {32'h0, lo}, 64'h0);
        chk("reset_stall", {63'h0, md_stall}, 64'h0);
        chk("reset_md_out", {32'h0, md_out}, 64'h0);
        @(posedge clk); #1;
        reset = 0;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, MC};
        vecs[1] = '{MD_DIVU,  32'h7,        32'h2,        32'h1,        32'h3,        DC};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[4] = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MC};
        vecs[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, DC};
        vecs[6] = '{MD_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, DC};
        vecs[7] = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, DC};

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            chk($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].cyc));
            chk($sformatf("vec%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].exp_hi});
            chk($sformatf("vec%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].exp_lo});
            set_in(MD_MFLO, 0, 0, 0, 0);
            #1;
            chk($sformatf("vec%0d_mflo", i), {32'h0, md_out}, {32'h0, vecs[i].exp_lo});
            tick();
        end

        // Divide by zero leaves HI/LO untouched but still takes the full latency.
        set_in(MD_MTHI, 32'h1234, 0, 0, 0); tick();
        set_in(MD_MTLO, 32'h5678, 0, 0, 0); tick();
        run_op(MD_DIV, 32'h7, 32'h0, n);
        chk("divz_cycles", 64'(n), 64'(DC));
        chk("divz_hi", {32'h0, hi}, 64'h1234);
        chk("divz_lo", {32'h0, lo}, 64'h5678);

        // Stall covers the start cycle and every busy cycle, drops when busy falls.
        set_in(MD_MULT, 32'h10000, 32'h30000, 0, 1);
        #1;
        chk("stall_start", {63'h0, md_stall}, 64'h1);
        tick();
        set_in(MD_NONE, 0, 0, 0, 1);
        n = 0;
        while (busy && n < 60) begin
            #1;
            chk("stall_busy", {63'h0, md_stall}, 64'h1);
            n++;
            tick();
        end
        chk("stall_cycles", 64'(n), 64'(MC));
        #1;
        chk("stall_free", {63'h0, md_stall}, 64'h0);
        set_in(MD_MFHI, 0, 0, 0, 1);
        #1;
        chk("stall_mfhi", {32'h0, md_out}, 64'h3);
        tick();

        // int_req kills a start and an MTHI in the same cycle.
        set_in(MD_MULT, 32'h5, 32'h5, 1, 0); tick();
        chk("intreq_busy", {63'h0, busy}, 64'h0);
        chk("intreq_hi", {32'h0, hi}, 64'h3);
        chk("intreq_lo", {32'h0, lo}, 64'h0);
        set_in(MD_MTHI, 32'hAAAA, 0, 1, 0); tick();
        chk("intreq_mthi", {32'h0, hi}, 64'h3);

        // MTHI and a second start while busy are both ignored.
        set_in(MD_MULT, 32'h2, 32'h3, 0, 0); tick();
        set_in(MD_MTHI, 32'hDEAD, 0, 0, 0); tick();
        set_in(MD_DIV, 32'h9, 32'h3, 0, 0); tick();
        set_in(MD_NONE, 0, 0, 0, 0);
        n = 0;
        while (busy && n < 60) begin n++; tick(); end
        chk("busy_ign_hi", {32'h0, hi}, 64'h0);
        chk("busy_ign_lo", {32'h0, lo}, 64'h6);

        // Reset during busy cycle 4 of a DIV clears at once and nothing commits later.
        set_in(MD_DIV, 32'd100, 32'd7, 0, 0); tick();
        set_in(MD_NONE, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick();
        chk("rst_mid_busy_before", {63'h0, busy}, 64'h1);
        reset = 1;
        #1;
        chk("rst_mid_busy", {63'h0, busy}, 64'h0);
        chk("rst_mid_hi", {32'h0, hi}, 64'h0);
        chk("rst_mid_lo", {32'h0, lo}, 64'h0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        for (int k = 0; k < 15; k++) tick();
        chk("rst_nocommit_hi", {32'h0, hi}, 64'h0);
        chk("rst_nocommit_lo", {32'h0, lo}, 64'h0);

`ifdef MDU_MADD_EN
        set_in(MD_MTHI, 32'h0, 0, 0, 0); tick();
        set_in(MD_MTLO, 32'hFFFFFFFF, 0, 0, 0); tick();
        run_op(MD_MADDU, 32'h1, 32'h1, n);
        chk("maddu_cycles", 64'(n), 64'(MC));
        chk("maddu_hi", {32'h0, hi}, 64'h1);
        chk("maddu_lo", {32'h0, lo}, 64'h0);
        run_op(MD_MADD, 32'hFFFFFFFF, 32'h1, n);
        chk("madd_hi", {32'h0, hi}, 64'h0);
        chk("madd_lo", {32'h0, lo}, 64'hFFFFFFFF);
`else
        set_in(MD_MADD, 32'h1, 32'h1, 0, 1);
        #1;
        chk("madd_off_stall", {63'h0, md_stall}, 64'h0);
        tick();
        chk("madd_off_busy", {63'h0, busy}, 64'h0);
`endif

        for (int k = 0; k < 3000; k++) begin
            set_in(4'($urandom_range(0, 10)), rnd_operand(), rnd_operand(),
                   ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
